// File: rtl/branch_target_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_target_predictor_pkg
// Shared definitions for the branch target predictor:
//   - ctr_e       : 2-bit bimodal counter states (SNT/WNT/WT/ST)
//   - PRED_STATIC : PRED_MODE code for static not-taken prediction
//   - PRED_BIMODAL: PRED_MODE code for the bimodal BTB
// -----------------------------------------------------------------------------
package branch_target_predictor_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,  // strongly not taken
        CTR_WNT = 2'b01,  // weakly not taken (reset state)
        CTR_WT  = 2'b10,  // weakly taken (fresh branch allocation)
        CTR_ST  = 2'b11   // strongly taken (jumps, saturated branches)
    } ctr_e;

    localparam int PRED_STATIC  = 0;
    localparam int PRED_BIMODAL = 1;

endpackage

// File: rtl/branch_target_predictor_sat_counter.sv
// -----------------------------------------------------------------------------
// bp_sat_counter2
// One 2-bit saturating direction counter of the BTB.
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset (-> WNT)
//   inc_i       : step towards taken, saturating at ST
//   dec_i       : step towards not taken, saturating at SNT
//   force_st_i  : load ST (jumps, jump allocation)
//   load_wt_i   : load WT (allocation of a conditional branch)
//   ctr_o       : current counter state
// Priority: force_st_i > load_wt_i > inc_i > dec_i.
// -----------------------------------------------------------------------------
module bp_sat_counter2
    import branch_target_predictor_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic dec_i,
    input  logic force_st_i,
    input  logic load_wt_i,
    output ctr_e ctr_o
);

    ctr_e ctr_q;
    ctr_e ctr_d;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        ctr_d = ctr_q;
        if (force_st_i) begin
            ctr_d = CTR_ST;
        end else if (load_wt_i) begin
            ctr_d = CTR_WT;
        end else if (inc_i && (ctr_q != CTR_ST)) begin
            ctr_d = ctr_e'(ctr_q + 2'd1);
        end else if (dec_i && (ctr_q != CTR_SNT)) begin
            ctr_d = ctr_e'(ctr_q - 2'd1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctr_q <= CTR_WNT;
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign ctr_o = ctr_q;

endmodule

// File: rtl/branch_target_predictor.sv
// -----------------------------------------------------------------------------
// branch_target_predictor
// Direct-mapped bimodal branch target buffer with a zero-latency lookup.
// Parameters:
//   XLEN      : address / target width
//   ENTRIES   : number of BTB entries (power of two, 2..256)
//   PRED_MODE : PRED_STATIC (always fall through) or PRED_BIMODAL
//   CNT_W     : width of the saturating mispredict counter
// Ports:
//   clk, reset           : rising-edge clock, synchronous active-high reset
//   if_pc                : fetch PC looked up combinationally
//   pred_hit/taken/npc   : lookup result (npc = target or if_pc+4)
//   upd_*                : resolved control-flow instruction (training)
//   bp_clear             : invalidate every entry at the next edge
//   mispred_cnt          : saturating count of reported mispredictions
// -----------------------------------------------------------------------------
module branch_target_predictor
    import branch_target_predictor_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ENTRIES   = 16,
    parameter int PRED_MODE = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  if_pc,
    output logic             pred_hit,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_npc,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic             upd_is_jump,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_mispred,
    input  logic             bp_clear,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam bit TABLES_EN = (PRED_MODE == PRED_BIMODAL);

    // Table state: valid/jump flags and counters are reset, tags and targets
    // are plain data qualified by valid.
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jump_q,  jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    ctr_e               ctr      [ENTRIES];
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit, wr_en, hit_wr, alloc;
    logic             upd_pc_unused;

    assign lk_idx = if_pc[IDX_W+1:2];
    assign lk_tag = if_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign upd_pc_unused = ^upd_pc[1:0];  // byte offset within the word

    // Training decode. bp_clear suppresses the whole update, and static mode
    // never writes the tables.
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign wr_en  = TABLES_EN && upd_valid && !bp_clear;
    assign hit_wr = wr_en && up_hit;
    assign alloc  = wr_en && !up_hit && upd_taken;

    always_comb begin
        valid_d = valid_q;
        jump_d  = jump_q;
        if (bp_clear) begin
            valid_d = '0;
        end else begin
            if (alloc) begin
                valid_d[up_idx] = 1'b1;
                jump_d[up_idx]  = upd_is_jump;
            end
            if (hit_wr && upd_is_jump) begin
                jump_d[up_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            jump_q  <= '0;
        end else begin
            valid_q <= valid_d;
            jump_q  <= jump_d;
        end
    end

    // NOTE: tag and target storage carries no reset; valid gates every use,
    // which keeps these wide arrays out of the reset tree.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (alloc) begin
                tag_q[up_idx] <= up_tag;
            end
            if (alloc || (hit_wr && upd_taken)) begin
                target_q[up_idx] <= upd_target;
            end
        end
    end

    // One direction counter per entry, steered by the decoded update.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
        logic sel;
        assign sel = (up_idx == IDX_W'(i));

        bp_sat_counter2 u_ctr (
            .clk        (clk),
            .reset      (reset),
            .inc_i      (sel && hit_wr && !upd_is_jump &&  upd_taken),
            .dec_i      (sel && hit_wr && !upd_is_jump && !upd_taken),
            .force_st_i (sel && (hit_wr || alloc) && upd_is_jump),
            .load_wt_i  (sel && alloc && !upd_is_jump),
            .ctr_o      (ctr[i])
        );
    end

    // Lookup reads registered state only, so a same-cycle update is not
    // visible until the following cycle.
    if (TABLES_EN) begin : g_lookup
        assign pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        assign pred_taken = pred_hit && (jump_q[lk_idx] || (ctr[lk_idx] >= CTR_WT));
        assign pred_npc   = pred_taken ? target_q[lk_idx] : if_pc + PC_STEP;
    end else begin : g_static
        assign pred_hit   = 1'b0;
        assign pred_taken = 1'b0;
        assign pred_npc   = if_pc + PC_STEP;
    end

    // Mispredict counter saturates at all-ones and ignores bp_clear.
    always_comb begin
        cnt_d = cnt_q;
        if (upd_valid && upd_mispred && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign mispred_cnt = cnt_q;

endmodule
